async_fifo_reader: RTL and testbench

Read-side consumer for the dual-clock `async_fifo` in its fall-through configuration. It pops words through `rinc`/`rdata`/`rempty` and re-presents them as a registered valid/ready stream to read-clock-domain logic. It also provides a synchronous flush that drains the FIFO, plus optional delivered/dropped word counters. It lives entirely in the read clock domain.

---
 rtl/async_fifo_reader_pkg.sv | 13 +
 rtl/async_fifo_reader_buf.sv | 38 +++
 rtl/async_fifo_reader.sv | 98 +++++++++
 tb/tb_async_fifo_reader.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_reader_pkg.sv
// Shared types for the async_fifo read-side consumer.
package async_fifo_reader_pkg;
  localparam int RD_BUF_DEPTH = 2;

  typedef logic [1:0] occ_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2,
    FLUSH = 2'd3
  } rd_state_e;
endpackage

// File: rtl/async_fifo_reader_buf.sv
// Two-entry registered FIFO-ordered skid buffer between the FIFO head and the stream.
module async_fifo_reader_buf
  import async_fifo_reader_pkg::*;
#(
  parameter int DSIZE = 8
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             push,
  input  logic [DSIZE-1:0] push_data,
  input  logic             pop,
  input  logic             clear,
  output logic [DSIZE-1:0] head,
  output occ_t             occ
);
  logic [RD_BUF_DEPTH-1:0][DSIZE-1:0] r_mem;
  occ_t                               r_occ;
  logic                               w_wr_idx;

  // Tail slot after any same-edge pop; a push into ONE with a pop lands in slot 0.
  assign w_wr_idx = r_occ[0] & ~pop;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_mem <= '0;
      r_occ <= '0;
    end else if (clear) begin
      r_occ <= '0;
    end else begin
      if (pop)  r_mem[0]        <= r_mem[1];
      if (push) r_mem[w_wr_idx] <= push_data;
      r_occ <= r_occ + occ_t'(push) - occ_t'(pop);
    end
  end

  assign head = r_mem[0];
  assign occ  = r_occ;
endmodule

// File: rtl/async_fifo_reader.sv
// Fall-through async_fifo read consumer: registered valid/ready stream, flush drain, stats.
// Counters exist only when ASYNC_FIFO_READER_STATS_EN is defined; otherwise tied to 0.
module async_fifo_reader
  import async_fifo_reader_pkg::*;
#(
  parameter int DSIZE = 8,
  parameter int CNT_W = 32
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic [DSIZE-1:0] rdata,
  input  logic             rempty,
  output logic             rinc,
  output logic [DSIZE-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             flush,
  output logic             flush_busy,
  output logic [CNT_W-1:0] delivered_cnt,
  output logic [CNT_W-1:0] dropped_cnt
);
  rd_state_e r_state, w_state_nxt;
  logic      w_push, w_xfer;
  occ_t      w_occ, w_occ_nxt;

  // Pop decision never depends on out_ready: the buffer absorbs one cycle of ready latency.
  assign rinc       = !rrst && !rempty && (r_state != TWO);
  assign w_push     = rinc && (r_state != FLUSH);
  assign out_valid  = (r_state == ONE) || (r_state == TWO);
  assign w_xfer     = out_valid && out_ready;
  assign flush_busy = (r_state == FLUSH);
  assign w_occ_nxt  = w_occ + occ_t'(w_push) - occ_t'(w_xfer);

  async_fifo_reader_buf #(.DSIZE(DSIZE)) u_buf (
    .rclk     (rclk),
    .rrst     (rrst),
    .push     (w_push),
    .push_data(rdata),
    .pop      (w_xfer),
    .clear    (flush),
    .head     (out_data),
    .occ      (w_occ)
  );

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) r_state <= EMPTY;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = FLUSH;
    end else if (r_state == FLUSH) begin
      if (rempty) w_state_nxt = EMPTY;
    end else begin
      case (w_occ_nxt)
        2'd0:    w_state_nxt = EMPTY;
        2'd1:    w_state_nxt = ONE;
        default: w_state_nxt = TWO;
      endcase
    end
  end

`ifdef ASYNC_FIFO_READER_STATS_EN
  logic [CNT_W-1:0] r_deliv, r_drop;
  logic [1:0]       w_drop_add;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  // On the flush edge the surviving occupancy (after any transfer, plus any push) is dropped.
  always_comb begin
    w_drop_add = '0;
    if (r_state == FLUSH) w_drop_add = {1'b0, rinc};
    else if (flush)       w_drop_add = w_occ_nxt;
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_deliv <= '0;
      r_drop  <= '0;
    end else begin
      r_deliv <= sat_add(r_deliv, {1'b0, w_xfer});
      r_drop  <= sat_add(r_drop, w_drop_add);
    end
  end

  assign delivered_cnt = r_deliv;
  assign dropped_cnt   = r_drop;
`else
  assign delivered_cnt = '0;
  assign dropped_cnt   = '0;
`endif
endmodule

// File: tb/tb_async_fifo_reader.sv
// Directed bench for async_fifo_reader with a queue-level reference model.
module tb_async_fifo_reader;
`ifdef ASYNC_FIFO_READER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        rclk = 1'b0;
  logic        rrst, rempty, out_ready, flush;
  logic [7:0]  rdata;
  logic        rinc, out_valid, flush_busy;
  logic [7:0]  out_data;
  logic [31:0] delivered_cnt, dropped_cnt;
  logic        rinc4, out_valid4, flush_busy4;
  logic [7:0]  out_data4;
  logic [3:0]  deliv4, drop4;

  always #5 rclk = ~rclk;

  async_fifo_reader #(.DSIZE(8), .CNT_W(32)) dut (
    .rclk(rclk), .rrst(rrst), .rdata(rdata), .rempty(rempty), .rinc(rinc),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .flush(flush), .flush_busy(flush_busy),
    .delivered_cnt(delivered_cnt), .dropped_cnt(dropped_cnt)
  );

  async_fifo_reader #(.DSIZE(8), .CNT_W(4)) dut4 (
    .rclk(rclk), .rrst(rrst), .rdata(rdata), .rempty(rempty), .rinc(rinc4),
    .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready),
    .flush(flush), .flush_busy(flush_busy4),
    .delivered_cnt(deliv4), .dropped_cnt(drop4)
  );

  // Model: the FIFO contents, the stream buffer contents, a flushing flag and counts.
  logic [7:0] fifo_q[$];
  logic [7:0] buf_q[$];
  bit         flushing;
  int         m_deliv, m_drop;

  int         n_chk = 0, n_pass = 0;
  int         n_rinc, n_valid, cyc = 0;
  logic [7:0] got[$];
  int         got_t[$];
  bit         chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [63:0] exp_cnt(input int v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    if (!STATS) return 64'd0;
    return (longint'(v) > mx) ? mx : longint'(v);
  endfunction

  function automatic bit exp_rinc();
    return !rrst && fifo_q.size() > 0 && (flushing || buf_q.size() < 2);
  endfunction

  task automatic model_reset();
    buf_q.delete();
    flushing = 1'b0;
    m_deliv  = 0;
    m_drop   = 0;
  endtask

  task automatic drive_fifo();
    rempty = (fifo_q.size() == 0);
    rdata  = rempty ? 8'h00 : fifo_q[0];
  endtask

  task automatic step();
    bit ri, xf, pre_empty;
    logic [7:0] w;
    drive_fifo();
    @(posedge rclk);
    if (rrst) begin
      model_reset();
    end else begin
      pre_empty = (fifo_q.size() == 0);
      ri = exp_rinc();
      xf = !flushing && buf_q.size() > 0 && out_ready;
      w  = 8'h00;
      if (ri) w = fifo_q.pop_front();
      if (flushing) begin
        if (ri) m_drop++;
        if (pre_empty && !flush) flushing = 1'b0;
      end else if (flush) begin
        if (xf) m_deliv++;
        m_drop += buf_q.size() - int'(xf) + int'(ri);
        buf_q.delete();
        flushing = 1'b1;
      end else begin
        if (xf) begin
          m_deliv++;
          void'(buf_q.pop_front());
        end
        if (ri) buf_q.push_back(w);
      end
    end
    #1 drive_fifo();
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  always @(negedge rclk) begin : cmp
    bit v, r;
    cyc++;
    if (chk_en) begin
      v = !flushing && buf_q.size() > 0;
      r = exp_rinc();
      chk("out_valid", out_valid, v);
      chk("out_valid4", out_valid4, v);
      if (v) begin
        chk("out_data", out_data, buf_q[0]);
        chk("out_data4", out_data4, buf_q[0]);
      end
      chk("rinc", rinc, r);
      chk("rinc4", rinc4, r);
      chk("flush_busy", flush_busy, flushing);
      chk("flush_busy4", flush_busy4, flushing);
      chk("delivered_cnt", delivered_cnt, exp_cnt(m_deliv, 32));
      chk("dropped_cnt", dropped_cnt, exp_cnt(m_drop, 32));
      chk("delivered4", deliv4, exp_cnt(m_deliv, 4));
      chk("dropped4", drop4, exp_cnt(m_drop, 4));
      if (rinc) n_rinc++;
      if (out_valid) n_valid++;
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        got_t.push_back(cyc);
      end
    end
  end

  initial begin
    bit ok;
    rrst = 1'b1; rempty = 1'b1; rdata = 8'h00; out_ready = 1'b0; flush = 1'b0;
    model_reset();
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_flush_busy", flush_busy, 0);
    chk("rst_rinc", rinc, 0);
    chk("rst_delivered", delivered_cnt, 0);
    chk("rst_dropped", dropped_cnt, 0);
    chk_en = 1'b1;
    run(2);
    rrst = 1'b0;
    step();

    // single word, 1-cycle latency
    out_ready = 1'b1;
    fifo_q.push_back(8'hA5);
    n_rinc = 0;
    step();
    chk("single_valid", out_valid, 1);
    chk("single_data", out_data, 8'hA5);
    step();
    chk("single_drained", out_valid, 0);
    chk("single_rinc_cnt", n_rinc, 1);
    chk("single_deliv", delivered_cnt, STATS ? 1 : 0);

    // 16-word stream at full rate
    for (int i = 0; i < 16; i++) fifo_q.push_back(8'(i));
    n_rinc = 0; n_valid = 0; got.delete(); got_t.delete();
    run(20);
    chk("stream_rinc_cnt", n_rinc, 16);
    chk("stream_valid_cnt", n_valid, 16);
    chk("stream_words", got.size(), 16);
    ok = (got.size() == 16);
    for (int i = 0; i < 16 && ok; i++) if (got[i] !== 8'(i)) ok = 1'b0;
    chk("stream_order", ok, 1);
    if (got_t.size() == 16) chk("stream_no_gap", got_t[15] - got_t[0], 15);
    else chk("stream_no_gap", got_t.size(), 16);
    chk("stream_deliv", delivered_cnt, STATS ? 17 : 0);

    // backpressure: only two pops, head held
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) fifo_q.push_back(8'h30 + 8'(i));
    n_rinc = 0;
    run(6);
    chk("bp_rinc_cnt", n_rinc, 2);
    chk("bp_rinc_low", rinc, 0);
    chk("bp_valid", out_valid, 1);
    chk("bp_head", out_data, 8'h30);
    got.delete();
    out_ready = 1'b1;
    run(8);
    ok = (got.size() == 5);
    for (int i = 0; i < 5 && ok; i++) if (got[i] !== 8'h30 + 8'(i)) ok = 1'b0;
    chk("bp_release_order", ok, 1);

    // flush from TWO with 3 words left in the FIFO
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) fifo_q.push_back(8'h40 + 8'(i));
    run(4);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_busy_rise", flush_busy, 1);
    chk("flush_valid_low", out_valid, 0);
    n_rinc = 0;
    run(3);
    chk("flush_busy_hold", flush_busy, 1);
    step();
    chk("flush_busy_fall", flush_busy, 0);
    chk("flush_rinc_cnt", n_rinc, 3);
    chk("flush_dropped", dropped_cnt, STATS ? 5 : 0);
    chk("flush_deliv", delivered_cnt, STATS ? 22 : 0);

    // flush coinciding with a push and a transfer in ONE
    out_ready = 1'b1;
    fifo_q.push_back(8'h50);
    fifo_q.push_back(8'h51);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush2_busy", flush_busy, 1);
    run(3);
    chk("flush2_exit", flush_busy, 0);
    chk("flush2_deliv", delivered_cnt, STATS ? 23 : 0);
    chk("flush2_dropped", dropped_cnt, STATS ? 6 : 0);

    // asynchronous reset with two words buffered
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) fifo_q.push_back(8'h60 + 8'(i));
    run(3);
    rrst = 1'b1;
    model_reset();
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_rinc", rinc, 0);
    chk("arst_deliv", delivered_cnt, 0);
    chk("arst_dropped", dropped_cnt, 0);
    chk("arst_busy", flush_busy, 0);
    step();
    rrst = 1'b0;
    out_ready = 1'b1;
    got.delete();
    run(5);
    chk("arst_resume_cnt", got.size(), 2);
    if (got.size() == 2) begin
      chk("arst_resume_w0", got[0], 8'h62);
      chk("arst_resume_w1", got[1], 8'h63);
    end
    chk("arst_resume_deliv", delivered_cnt, STATS ? 2 : 0);

    // 4-bit counter saturation
    for (int i = 0; i < 20; i++) fifo_q.push_back(8'h70 + 8'(i));
    run(25);
    chk("sat_deliv4", deliv4, STATS ? 4'hF : 4'h0);
    chk("sat_deliv32", delivered_cnt, STATS ? 22 : 0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
